p2s_word_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one wide-word parallel-to-serial serializer among `NUM_REQ` requesters. It selects a requesting source, captures that source's word, and issues a single-cycle load into the serializer. It then tracks the serializer's busy signal through the complete shift-out and returns a one-cycle acknowledge to the winning source. It sits between the protocol framers that produce `P_WIDTH` words and the serializer that feeds the UART byte path.

---
 rtl/p2s_word_arbiter.sv | 137 +++++++++++++
 tb/tb_p2s_word_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p2s_word_arbiter.sv
// p2s_word_arbiter: shares one wide-word parallel-to-serial serializer among NUM_REQ requesters.
// Build option: define P2S_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module p2s_word_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int P_WIDTH = 24,
  parameter int TIMEOUT = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*P_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         p2s_load,
  output logic [P_WIDTH-1:0]           p2s_data,
  input  logic                         p2s_busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         active,
  output logic                         err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic                 load_next, err_next, found;
  logic [P_WIDTH-1:0]   data_next, winner_word;
  logic [IDW-1:0]       gid_next, winner;
  logic [IDW:0]         idx;
  logic [NUM_REQ-1:0]   ack_next;
`ifndef P2S_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]       ptr, ptr_next;
`endif

  // Winner search: upward from ptr with wrap-around, or from index 0 in the fixed-priority build.
  always_comb begin
    found       = 1'b0;
    winner      = '0;
    idx         = '0;
    winner_word = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef P2S_ARB_FIXED_PRIO_EN
      idx = (IDW+1)'(k);
`else
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
`endif
      if (!found && req[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
    for (int j = 0; j < NUM_REQ; j++)
      if (winner == IDW'(j)) winner_word = req_data[j*P_WIDTH +: P_WIDTH];
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_next  = 1'b0;
    err_next   = 1'b0;
    ack_next   = '0;
    data_next  = p2s_data;
    gid_next   = grant_id;
`ifndef P2S_ARB_FIXED_PRIO_EN
    ptr_next   = ptr;
`endif
    unique case (state)
      // The ack cycle is skipped: the acked source still shows its old request level then.
      IDLE: begin
        if (found && !p2s_busy && ack == '0) begin
          state_next = LOAD;
          load_next  = 1'b1;
          data_next  = winner_word;
          gid_next   = winner;
        end
      end
      LOAD: begin
        cnt_next   = '0;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (p2s_busy) begin
          state_next = WAIT_DONE;
        end else begin
          cnt_next = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!p2s_busy) begin
          ack_next[grant_id] = 1'b1;
`ifndef P2S_ARB_FIXED_PRIO_EN
          ptr_next = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
`endif
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      p2s_load <= 1'b0;
      p2s_data <= '0;
      grant_id <= '0;
      ack      <= '0;
      err      <= 1'b0;
`ifndef P2S_ARB_FIXED_PRIO_EN
      ptr      <= '0;
`endif
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      p2s_load <= load_next;
      p2s_data <= data_next;
      grant_id <= gid_next;
      ack      <= ack_next;
      err      <= err_next;
`ifndef P2S_ARB_FIXED_PRIO_EN
      ptr      <= ptr_next;
`endif
    end
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_p2s_word_arbiter.sv
// tb_p2s_word_arbiter: randomized and directed scenarios against a transaction-level arbitration model.
// A 3-cycle busy serializer model sits on the p2s side; P2S_ARB_FIXED_PRIO_EN switches the model too.
module tb_p2s_word_arbiter;

  localparam int NR = 3;
  localparam int PW = 24;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*PW-1:0] req_data = '0;
  logic [NR-1:0] ack;
  logic          p2s_load;
  logic [PW-1:0] p2s_data;
  logic          p2s_busy;
  logic [1:0]    grant_id;
  logic          active;
  logic          err;

  logic          force_busy = 1'b0;
  logic          ser_dead = 1'b0;
  int            bcnt = 0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  int            load_cyc_q[$];
  int            load_gid_q[$];
  logic [PW-1:0] load_data_q[$];
  int            ack_cyc_q[$];
  logic [NR-1:0] ack_val_q[$];
  int            err_cyc_q[$];
  logic [PW-1:0] ser_q[$];

  p2s_word_arbiter #(.NUM_REQ(NR), .P_WIDTH(PW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .p2s_load(p2s_load), .p2s_data(p2s_data), .p2s_busy(p2s_busy),
    .grant_id(grant_id), .active(active), .err(err)
  );

  always #5 clk = ~clk;

  // Serializer model: busy for 3 cycles after each accepted load, captures the loaded word.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) bcnt <= 0;
    else if (p2s_load && !ser_dead) begin
      bcnt <= 3;
      ser_q.push_back(p2s_data);
    end else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign p2s_busy = force_busy || (bcnt != 0);

  always @(negedge clk) begin
    if (p2s_load) begin
      load_cyc_q.push_back(cyc);
      load_gid_q.push_back(int'(grant_id));
      load_data_q.push_back(p2s_data);
    end
    if (ack != '0) begin
      ack_cyc_q.push_back(cyc);
      ack_val_q.push_back(ack);
    end
    if (err) err_cyc_q.push_back(cyc);
  end

  function automatic int model_pick(input logic [NR-1:0] m, input int p);
    int w;
    w = -1;
`ifdef P2S_ARB_FIXED_PRIO_EN
    for (int i = NR - 1; i >= 0; i--) if (m[i]) w = i;
`else
    for (int k = NR - 1; k >= 0; k--) if (m[(p + k) % NR]) w = (p + k) % NR;
`endif
    return w;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_queues;
    load_cyc_q.delete(); load_gid_q.delete(); load_data_q.delete();
    ack_cyc_q.delete(); ack_val_q.delete(); err_cyc_q.delete(); ser_q.delete();
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; req = '0; force_busy = 1'b0; ser_dead = 1'b0;
    step(2);
    rst = 1'b0;
    clear_queues();
  endtask

  task automatic test_reset;
    int t;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    t = cyc;
    req_data[2*PW +: PW] = PW'($urandom) | 24'h1;
    req = 3'b100;
    step(1);
    checks++;
    if (p2s_load !== 1'b1) begin errors++; $display("FAIL reset_pre_load: got %b expected 1", p2s_load); end
    rst = 1'b1;
    step(1);
    checks++; if (ack !== '0) begin errors++; $display("FAIL reset_ack: got %b expected 000", ack); end
    checks++; if (p2s_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", p2s_load); end
    checks++; if (p2s_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", p2s_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    if (t < 0) $display("[TB] unreachable");
    rst = 1'b0; req = '0;
    clear_queues();
  endtask

  task automatic test_single;
    int t, got;
    do_reset();
    t = cyc;
    req_data = {PW'($urandom), PW'($urandom), 24'hA1B2C3};
    req = 3'b001;
    step(6);
    req = '0;
    step(4);
    checks++; if (load_cyc_q.size() != 1) begin errors++; $display("FAIL single_load_count: got %0d expected 1", load_cyc_q.size()); end
    got = (load_cyc_q.size() > 0) ? load_cyc_q[0] - t : -1;
    checks++; if (got != 1) begin errors++; $display("FAIL single_load_cycle: got T+%0d expected T+1", got); end
    checks++; if (load_data_q.size() == 0 || load_data_q[0] !== 24'hA1B2C3) begin errors++; $display("FAIL single_load_data: expected a1b2c3 (loads=%0d)", load_data_q.size()); end
    got = (ack_cyc_q.size() > 0) ? ack_cyc_q[0] - t : -1;
    checks++; if (ack_cyc_q.size() != 1 || got != 6) begin errors++; $display("FAIL single_ack_cycle: got T+%0d count %0d expected T+6 count 1", got, ack_cyc_q.size()); end
    checks++; if (ack_val_q.size() == 0 || ack_val_q[0] !== 3'b001) begin errors++; $display("FAIL single_ack_value: expected 001 (acks=%0d)", ack_val_q.size()); end
    checks++; if (ser_q.size() != 1 || ser_q[0] !== 24'hA1B2C3) begin errors++; $display("FAIL single_ser_word: count %0d expected 1 word a1b2c3", ser_q.size()); end
  endtask

  task automatic test_contention;
    int t, p, w, gc, gg, ac;
    logic [NR-1:0] av;
    do_reset();
    t = cyc;
    req_data = {PW'($urandom), PW'($urandom), PW'($urandom)};
    req = 3'b111;
    step(27);
    req = '0;
    step(4);
    p = 0;
    checks++; if (load_cyc_q.size() != 4 || ack_cyc_q.size() != 4) begin errors++; $display("FAIL contention_counts: loads %0d acks %0d expected 4 and 4", load_cyc_q.size(), ack_cyc_q.size()); end
    for (int i = 0; i < 4; i++) begin
      w  = model_pick(3'b111, p);
      gc = (i < load_cyc_q.size()) ? load_cyc_q[i] - t : -1;
      gg = (i < load_gid_q.size()) ? load_gid_q[i] : -1;
      ac = (i < ack_cyc_q.size()) ? ack_cyc_q[i] - t : -1;
      av = (i < ack_val_q.size()) ? ack_val_q[i] : '0;
      checks++; if (gc != 1 + 7*i || gg != w) begin errors++; $display("FAIL contention_grant%0d: got T+%0d id %0d expected T+%0d id %0d", i, gc, gg, 1 + 7*i, w); end
      checks++; if (ac != 6 + 7*i || av !== NR'(1 << w)) begin errors++; $display("FAIL contention_ack%0d: got T+%0d %b expected T+%0d %b", i, ac, av, 6 + 7*i, NR'(1 << w)); end
      p = (w + 1) % NR;
    end
  endtask

  task automatic test_busy_at_request;
    int t, gc, ac;
    do_reset();
    t = cyc;
    force_busy = 1'b1;
    req_data = {PW'($urandom), PW'($urandom), PW'($urandom)};
    req = 3'b010;
    step(3);
    force_busy = 1'b0;
    step(6);
    req = '0;
    step(3);
    gc = (load_cyc_q.size() > 0) ? load_cyc_q[0] - t : -1;
    checks++; if (load_cyc_q.size() != 1 || gc != 4) begin errors++; $display("FAIL busy_load: got T+%0d count %0d expected T+4 count 1", gc, load_cyc_q.size()); end
    ac = (ack_cyc_q.size() > 0) ? ack_cyc_q[0] - t : -1;
    checks++; if (ac != 9 || ack_val_q.size() != 1 || ack_val_q[0] !== 3'b010) begin errors++; $display("FAIL busy_ack: got T+%0d count %0d expected T+9 010", ac, ack_cyc_q.size()); end
  endtask

  task automatic test_dead_serializer;
    int t, e, l2;
    do_reset();
    t = cyc;
    ser_dead = 1'b1;
    req_data = {PW'($urandom), PW'($urandom), PW'($urandom)};
    req = 3'b001;
    step(17);
    req = '0;
    step(3);
    e = (err_cyc_q.size() > 0) ? err_cyc_q[0] - t : -1;
    checks++; if (err_cyc_q.size() != 1 || e != 1 + TO) begin errors++; $display("FAIL dead_err: got T+%0d count %0d expected T+%0d count 1", e, err_cyc_q.size(), 1 + TO); end
    checks++; if (ack_cyc_q.size() != 0) begin errors++; $display("FAIL dead_no_ack: got %0d acks expected 0", ack_cyc_q.size()); end
    l2 = (load_cyc_q.size() > 1) ? load_cyc_q[1] - t : -1;
    checks++; if (l2 != 2 + TO || load_gid_q.size() < 2 || load_gid_q[1] != 0) begin errors++; $display("FAIL dead_regrant: got T+%0d expected T+%0d source 0", l2, 2 + TO); end
  endtask

  task automatic test_mid_transfer;
    int t, ac;
    logic [PW-1:0] w;
    do_reset();
    t = cyc;
    w = PW'($urandom);
    req_data = {w, PW'($urandom), PW'($urandom)};
    req = 3'b100;
    step(3);
    req = '0;
    req_data[2*PW +: PW] = ~w;
    step(6);
    ac = (ack_cyc_q.size() > 0) ? ack_cyc_q[0] - t : -1;
    checks++; if (ack_cyc_q.size() != 1 || ac != 6 || ack_val_q[0] !== 3'b100) begin errors++; $display("FAIL mid_ack: got T+%0d count %0d expected T+6 100", ac, ack_cyc_q.size()); end
    checks++; if (ser_q.size() != 1 || ser_q[0] !== w) begin errors++; $display("FAIL mid_word: count %0d expected word %h", ser_q.size(), w); end
  endtask

  task automatic test_reset_in_wait_done;
    int t, gg;
    do_reset();
    req_data = {PW'($urandom), PW'($urandom), PW'($urandom)};
    req = 3'b001;
    step(6);
    req = '0;
    step(3);
    req = 3'b010;
    step(3);
    rst = 1'b1; req = '0;
    step(1);
    checks++; if (ack !== '0) begin errors++; $display("FAIL rstwd_ack: got %b expected 000", ack); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL rstwd_active: got %b expected 0", active); end
    rst = 1'b0;
    step(2);
    clear_queues();
    t = cyc;
    req = 3'b011;
    step(6);
    req = '0;
    step(3);
    gg = (load_gid_q.size() > 0) ? load_gid_q[0] : -1;
    checks++; if (gg != 0 || load_cyc_q.size() != 1 || load_cyc_q[0] - t != 1) begin errors++; $display("FAIL rstwd_ptr: got source %0d expected 0 at T+1", gg); end
  endtask

  task automatic test_held_pair;
    int t, p, w, gg;
    do_reset();
    t = cyc;
    req_data = {PW'($urandom), PW'($urandom), PW'($urandom)};
    req = 3'b110;
    step(20);
    req = '0;
    step(4);
    p = 0;
    checks++; if (load_cyc_q.size() != 3) begin errors++; $display("FAIL pair_count: got %0d loads expected 3", load_cyc_q.size()); end
    for (int i = 0; i < 3; i++) begin
      w  = model_pick(3'b110, p);
      gg = (i < load_gid_q.size()) ? load_gid_q[i] : -1;
      checks++; if (gg != w) begin errors++; $display("FAIL pair_grant%0d: got %0d expected %0d", i, gg, w); end
      p = (w + 1) % NR;
    end
  endtask

  task automatic test_random;
    int t, p, w, gc, ac;
    logic [NR-1:0] m;
    logic [PW-1:0] words [NR];
    do_reset();
    p = 0;
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      clear_queues();
      t = cyc;
      m = NR'($urandom_range(1, 7));
      for (int i = 0; i < NR; i++) begin
        words[i] = PW'($urandom);
        req_data[i*PW +: PW] = words[i];
      end
      req = m;
      step(2);
      req_data = {PW'($urandom), PW'($urandom), PW'($urandom)};
      step(4);
      req = '0;
      step(3);
      w  = model_pick(m, p);
      gc = (load_cyc_q.size() > 0) ? load_cyc_q[0] - t : -1;
      ac = (ack_cyc_q.size() > 0) ? ack_cyc_q[0] - t : -1;
      checks++; if (load_cyc_q.size() != 1 || gc != 1 || load_gid_q[0] != w) begin errors++; $display("FAIL rand%0d_grant: req %b got T+%0d count %0d expected T+1 source %0d", r, m, gc, load_cyc_q.size(), w); end
      checks++; if (load_data_q.size() == 0 || load_data_q[0] !== words[w]) begin errors++; $display("FAIL rand%0d_data: expected %h", r, words[w]); end
      checks++; if (ack_cyc_q.size() != 1 || ac != 6 || ack_val_q[0] !== NR'(1 << w)) begin errors++; $display("FAIL rand%0d_ack: got T+%0d count %0d expected T+6 %b", r, ac, ack_cyc_q.size(), NR'(1 << w)); end
      p = (w + 1) % NR;
    end
  endtask

  initial begin
    $display("[TB] starting p2s_word_arbiter bench");
    test_reset();
    test_single();
    test_contention();
    test_busy_at_request();
    test_dead_serializer();
    test_mid_transfer();
    test_reset_in_wait_done();
    test_held_pair();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
